// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - MEM-stage data RAM target with programmable wait states
// Stalls the pipeline for each load/store, then pulses Done with registered ReadData/Err.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          op_rd, op_wr;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          req, access, bad;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [31:0]   rword, shifted, load_val, store_val;
  logic [3:0]    be;
  logic [31:0]   mem [DEPTH_WORDS];

  // Address bits above the RAM window alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addr[31:AW+2];

  assign req    = MemRead | MemWrite;
  assign access = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Stall = 1'b0;
    Done  = 1'b0;
    case (state)
      IDLE:    Stall = req & rst_n;
      BUSY:    Stall = 1'b1;
      DONE:    Done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      op_rd   <= 1'b0;
      op_wr   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else if (state == IDLE && req) begin
      cnt     <= 4'(WAIT_STATES - 1);
      op_rd   <= MemRead;
      op_wr   <= MemWrite;
      f3_q    <= Funct3;
      addr_q  <= Addr[AW+1:0];
      wdata_q <= WriteData;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign word_idx = addr_q[AW+1:2];
  assign lane     = addr_q[1:0];
  assign rword    = mem[word_idx];
  assign shifted  = rword >> {lane, 3'b000};

  always_comb begin
    bad = 1'b0;
    if (op_rd && op_wr)                                     bad = 1'b1;
    if (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111) bad = 1'b1;
    if (op_wr && f3_q[2])                                   bad = 1'b1;
    if (f3_q[1:0] == 2'b01 && lane[0])                      bad = 1'b1;
    if (f3_q == 3'b010 && lane != 2'b00)                    bad = 1'b1;
  end

  always_comb begin
    load_val = 32'd0;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_val = rword;
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = 32'd0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_val = wdata_q;
    be        = 4'b1111;
    case (f3_q[1:0])
      2'b00:   begin store_val = {4{wdata_q[7:0]}};  be = 4'b0001 << lane; end
      2'b01:   begin store_val = {2{wdata_q[15:0]}}; be = 4'b0011 << lane; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && op_wr && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= store_val[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ReadData <= 32'd0;
      Err      <= 1'b0;
    end else if (access) begin
      if (bad) begin
        Err      <= 1'b1;
        ReadData <= 32'd0;
      end else begin
        Err <= 1'b0;
        if (op_rd) ReadData <= load_val;
      end
    end
  end
endmodule
